rob_commit_unit: RTL and testbench
==================================

// Module: rob_commit_unit
// PURPOSE
//  Retire side of the 8-entry reorder buffer. Issue allocates ROB indices in order (inst_count % 8)
//  and stalls on the busy_rb bits. This block holds each entry's state, captures CDB results,
//  and retires entries strictly in program order from the head pointer. Retirement writes the
//  register file or performs a store request/ack with memory. It then frees the entry back to issue.
// PARAMETERS
//  DATA_W    32  result / store-data width
//  REG_W     5   destination register index width
//  ROB_DEPTH 8   entries; power of 2; IDX_W = $clog2(ROB_DEPTH) = 3
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       async active-low reset
//  start          in   1       0 = pipeline idle/flush (same signal that clears the issue counter)
//  issue_valid    in   1       issue accepted an instruction this cycle (no struct hazard)
//  issue_rob_idx  in   IDX_W   entry being allocated
//  issue_dest     in   REG_W   destination register (ignored for stores)
//  issue_is_store in   1       entry is a STORE
//  cdb_valid      in   1       result broadcast on the common data bus
//  cdb_rob_idx    in   IDX_W   producing entry
//  cdb_value      in   DATA_W  result (store: data to write)
//  cdb_addr       in   DATA_W  effective address (stores only)
//  store_ack      in   1       memory accepted the pending store
//  busy_rb        out  8       bit i = entry i allocated; feeds issue busy_rb0..busy_rb7
//  rf_we          out  1       one-cycle register writeback pulse
//  rf_waddr       out  REG_W   writeback register
//  rf_wdata       out  DATA_W  writeback value
//  store_req      out  1       store pending to memory; held until store_ack
//  store_addr     out  DATA_W  store address
//  store_data     out  DATA_W  store data
//  head_idx       out  IDX_W   oldest un-retired entry
//  retire_count   out  32      instructions retired since start rose
//  alloc_err      out  1       sticky: issue targeted an already-busy entry
// BEHAVIOUR
//  Reset (rst_n low, async): busy/done of all entries = 0, head_idx = 0, FSM = RUN.
//   All outputs 0: rf_we, store_req, retire_count, alloc_err.
//  start low (sync): same clearing as reset on each clk edge. All inputs are ignored.
//   This is required to stay consistent with the issue counter restarting at ROB 0.
//  Per entry: busy, done, is_store, dest, value, addr.
//  Allocate: issue_valid sets busy=1, done=0 and loads is_store/dest at issue_rob_idx.
//   If the entry is already busy, the entry is left unchanged and alloc_err is set (sticky until start low/reset).
//  Capture: cdb_valid on a busy && !done entry sets done=1 and latches value/addr.
//   A CDB hit on a free or done entry is ignored.
//   If cdb and issue hit the same idx in the same cycle, the allocation wins and the CDB is dropped.
//  FSM RUN: if entry[head] is busy && done && !is_store, then at the next edge:
//   - rf_we=1, rf_waddr=dest, rf_wdata=value
//   - busy[head]=0, head_idx+1 mod 8, retire_count+1
//   This allows a maximum retire rate of 1 per cycle.
//  FSM RUN, store case: if entry[head] is busy && done && is_store, then at the next edge:
//   - go to STORE_WAIT with store_req=1 and store_addr/store_data registered from the entry
//   - no RF write
//  FSM STORE_WAIT: store_req, addr and data are held stable.
//   On the edge where store_ack=1: store_req=0, busy[head]=0, head+1, retire_count+1, back to RUN.
//   The next entry can retire no earlier than the following cycle.
//  store_ack in RUN is ignored.
//  Head stalls while entry[head] is not done. Younger done entries wait (in-order commit).
//  Wrap-around: head 7 -> 0. All 8 busy => issue sees a full ROB. A freed bit is visible to issue the cycle after retirement.
//  Same-cycle retire of head and allocation of another free entry are both performed.
//   The freed head cannot be re-allocated in the same cycle, because busy_rb is registered.
//  retire_count wraps modulo 2^32.
// TESTING
//  1. Reset, start=1, issue ROB0..2 (dest r1,r2,r3), then CDB 2,0,1 values 30,10,20 ->
//     rf writes r1=10, r2=20, r3=30 in that order, on consecutive cycles after CDB1;
//     busy_rb returns to 8'h00 and retire_count=3.
//  2. Fill all 8 entries with no CDB -> busy_rb=8'hFF.
//     Then CDB idx0 -> bit0 clears one cycle after the rf_we pulse and head_idx=1.
//  3. Store at head with addr=0x40, data=0x55 -> store_req held with 0x40/0x55.
//     store_ack delayed 3 cycles -> no RF write, entry freed only on the ack edge.
//  4. Issue and CDB to the same idx in one cycle -> entry stays not-done. A later CDB completes it.
//  5. start dropped while 5 entries are busy and STORE_WAIT is pending ->
//     next edge busy_rb=0, head_idx=0, store_req=0.
//     Async rst_n mid-stream clears the same state immediately.
//  6. Wrap test: 20 instructions issued through entries 0..7,0..7,0..3 -> 20 retires, head_idx=4, alloc_err=0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Retire side of the reorder buffer: per-entry state, CDB capture and strictly
// in-order commit from the head (register writeback or store request/ack).
module rob_commit_unit #(
  parameter  int DATA_W    = 32,
  parameter  int REG_W     = 5,
  parameter  int ROB_DEPTH = 8,
  localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 issue_valid,
  input  logic [IDX_W-1:0]     issue_rob_idx,
  input  logic [REG_W-1:0]     issue_dest,
  input  logic                 issue_is_store,
  input  logic                 cdb_valid,
  input  logic [IDX_W-1:0]     cdb_rob_idx,
  input  logic [DATA_W-1:0]    cdb_value,
  input  logic [DATA_W-1:0]    cdb_addr,
  input  logic                 store_ack,
  output logic [ROB_DEPTH-1:0] busy_rb,
  output logic                 rf_we,
  output logic [REG_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 store_req,
  output logic [DATA_W-1:0]    store_addr,
  output logic [DATA_W-1:0]    store_data,
  output logic [IDX_W-1:0]     head_idx,
  output logic [31:0]          retire_count,
  output logic                 alloc_err
);

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_STORE_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ROB_DEPTH-1:0] r_busy;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_is_store;
  logic [REG_W-1:0]     r_dest  [ROB_DEPTH];
  logic [DATA_W-1:0]    r_value [ROB_DEPTH];
  logic [DATA_W-1:0]    r_addr  [ROB_DEPTH];
  logic [IDX_W-1:0]     r_head;
  logic [31:0]          r_retire_count;
  logic [ROB_DEPTH-1:0] r_busy_rb;
  logic                 r_rf_we;
  logic [REG_W-1:0]     r_rf_waddr;
  logic [DATA_W-1:0]    r_rf_wdata;
  logic                 r_store_req;
  logic [DATA_W-1:0]    r_store_addr;
  logic [DATA_W-1:0]    r_store_data;
  logic                 r_alloc_err;
  logic                 w_head_ready;
  logic                 w_retire;
  logic                 w_rf_write;
  logic                 w_store_issue;

  // Commit decision: retire a done ALU entry directly, or launch/finish a store
  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_rf_write    = 1'b0;
    w_store_issue = 1'b0;
    w_head_ready  = r_busy[r_head] & r_done[r_head];
    case (r_state)
      ST_RUN: begin
        if (w_head_ready && !r_is_store[r_head]) begin
          w_retire   = 1'b1;
          w_rf_write = 1'b1;
        end else if (w_head_ready) begin
          w_store_issue = 1'b1;
          w_next_state  = ST_STORE_WAIT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_STORE_WAIT: begin
        if (store_ack) begin
          w_retire     = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_STORE_WAIT;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Commit FSM state register; start low forces RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (!start) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Entry table: allocation beats a same-index CDB, retire frees the head last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_done     <= '0;
      r_is_store <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_dest[i]  <= '0;
        r_value[i] <= '0;
        r_addr[i]  <= '0;
      end
    end else if (!start) begin
      r_busy     <= '0;
      r_done     <= '0;
      r_is_store <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (issue_valid && (issue_rob_idx == IDX_W'(i))) begin
          if (!r_busy[i]) begin
            r_busy[i]     <= 1'b1;
            r_done[i]     <= 1'b0;
            r_is_store[i] <= issue_is_store;
            r_dest[i]     <= issue_dest;
          end
        end else if (cdb_valid && (cdb_rob_idx == IDX_W'(i)) && r_busy[i] && !r_done[i]) begin
          r_done[i]  <= 1'b1;
          r_value[i] <= cdb_value;
          r_addr[i]  <= cdb_addr;
        end
        if (w_retire && (r_head == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
          r_done[i] <= 1'b0;
        end
      end
    end
  end

  // Registered commit outputs, head pointer, counters and the delayed busy view
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_rb      <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_store_req    <= 1'b0;
      r_store_addr   <= '0;
      r_store_data   <= '0;
      r_head         <= '0;
      r_retire_count <= 32'd0;
      r_alloc_err    <= 1'b0;
    end else if (!start) begin
      r_busy_rb      <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_store_req    <= 1'b0;
      r_store_addr   <= '0;
      r_store_data   <= '0;
      r_head         <= '0;
      r_retire_count <= 32'd0;
      r_alloc_err    <= 1'b0;
    end else begin
      r_busy_rb <= r_busy;
      r_rf_we   <= w_rf_write;
      if (w_rf_write) begin
        r_rf_waddr <= r_dest[r_head];
        r_rf_wdata <= r_value[r_head];
      end
      if (w_store_issue) begin
        r_store_req  <= 1'b1;
        r_store_addr <= r_addr[r_head];
        r_store_data <= r_value[r_head];
      end else if (w_retire) begin
        r_store_req <= 1'b0;
      end
      if (w_retire) begin
        r_head         <= r_head + IDX_W'(1);
        r_retire_count <= r_retire_count + 32'd1;
      end
      if (issue_valid && r_busy[issue_rob_idx]) begin
        r_alloc_err <= 1'b1;
      end
    end
  end

  assign busy_rb      = r_busy_rb;
  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign store_req    = r_store_req;
  assign store_addr   = r_store_addr;
  assign store_data   = r_store_data;
  assign head_idx     = r_head;
  assign retire_count = r_retire_count;
  assign alloc_err    = r_alloc_err;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed plus randomized bench for rob_commit_unit; every output is compared
// each cycle against a behavioural model of the reorder buffer's commit rules.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_rob_idx = 3'd0;
  logic [4:0]  issue_dest = 5'd0;
  logic        issue_is_store = 1'b0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_rob_idx = 3'd0;
  logic [31:0] cdb_value = 32'd0;
  logic [31:0] cdb_addr = 32'd0;
  logic        store_ack = 1'b0;
  logic [7:0]  busy_rb;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        store_req;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [2:0]  head_idx;
  logic [31:0] retire_count;
  logic        alloc_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .issue_valid(issue_valid), .issue_rob_idx(issue_rob_idx),
    .issue_dest(issue_dest), .issue_is_store(issue_is_store),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .cdb_value(cdb_value), .cdb_addr(cdb_addr), .store_ack(store_ack),
    .busy_rb(busy_rb), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .head_idx(head_idx), .retire_count(retire_count), .alloc_err(alloc_err)
  );

  // Reference model: the ROB as a table of entries plus a head index
  bit          m_busy [8];
  bit          m_done [8];
  bit          m_st   [8];
  logic [4:0]  m_dest [8];
  logic [31:0] m_val  [8];
  logic [31:0] m_addr [8];
  int          m_head;
  int          m_cnt;
  bit          m_in_store;
  logic [31:0] m_saddr, m_sdata;
  bit          m_rf_we;
  logic [4:0]  m_rf_waddr;
  logic [31:0] m_rf_wdata;
  logic [7:0]  m_vis;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
    m_head = 0; m_cnt = 0; m_in_store = 1'b0; m_rf_we = 1'b0;
    m_vis = 8'h00; m_err = 1'b0;
  endtask

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock of ROB behaviour, evaluated from the inputs presented this cycle
  task automatic model_step();
    int  h;
    bit  ready, done_rf, launch, done_st;
    int  ci;
    if (!start) begin
      model_clear();
      return;
    end
    h       = m_head;
    m_vis   = busy_vec();
    ready   = m_busy[h] && m_done[h];
    done_rf = !m_in_store && ready && !m_st[h];
    launch  = !m_in_store && ready && m_st[h];
    done_st = m_in_store && store_ack;
    m_rf_we = done_rf;
    if (done_rf) begin
      m_rf_waddr = m_dest[h];
      m_rf_wdata = m_val[h];
    end
    if (launch) begin
      m_in_store = 1'b1;
      m_saddr = m_addr[h];
      m_sdata = m_val[h];
    end
    if (done_st) m_in_store = 1'b0;
    if (issue_valid) begin
      if (m_busy[issue_rob_idx]) m_err = 1'b1;
      else begin
        m_busy[issue_rob_idx] = 1'b1;
        m_done[issue_rob_idx] = 1'b0;
        m_st[issue_rob_idx]   = issue_is_store;
        m_dest[issue_rob_idx] = issue_dest;
      end
    end
    ci = int'(cdb_rob_idx);
    if (cdb_valid && !(issue_valid && issue_rob_idx == cdb_rob_idx) && m_busy[ci] && !m_done[ci]) begin
      m_done[ci] = 1'b1;
      m_val[ci]  = cdb_value;
      m_addr[ci] = cdb_addr;
    end
    if (done_rf || done_st) begin
      m_busy[h] = 1'b0;
      m_head = (h + 1) % 8;
      m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("busy_rb", 32'(busy_rb), 32'(m_vis));
    chk("rf_we", 32'(rf_we), 32'(m_rf_we));
    if (m_rf_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_rf_waddr));
      chk("rf_wdata", rf_wdata, m_rf_wdata);
    end
    chk("store_req", 32'(store_req), 32'(m_in_store));
    if (m_in_store) begin
      chk("store_addr", store_addr, m_saddr);
      chk("store_data", store_data, m_sdata);
    end
    chk("head_idx", 32'(head_idx), 32'(m_head));
    chk("retire_count", retire_count, 32'(m_cnt));
    chk("alloc_err", 32'(alloc_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; cdb_valid = 1'b0; store_ack = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic issue(input int idx, input int dest, input bit st);
    issue_valid = 1'b1; issue_rob_idx = 3'(idx); issue_dest = 5'(dest); issue_is_store = st;
    cycle();
    idle_inputs();
  endtask

  task automatic cdb(input int idx, input logic [31:0] val, input logic [31:0] addr);
    cdb_valid = 1'b1; cdb_rob_idx = 3'(idx); cdb_value = val; cdb_addr = addr;
    cycle();
    idle_inputs();
  endtask

  task automatic restart();
    start = 1'b0;
    cycle();
    start = 1'b1;
  endtask

  initial begin
    int nxt;
    model_clear();
    #12;
    check_all();
    chk("reset_busy_rb", 32'(busy_rb), 32'h0);
    chk("reset_store_req", 32'(store_req), 32'h0);
    rst_n = 1'b1;
    start = 1'b1;

    // Out-of-order completion, in-order writeback
    issue(0, 1, 1'b0); issue(1, 2, 1'b0); issue(2, 3, 1'b0);
    cdb(2, 32'd30, 32'd0); cdb(0, 32'd10, 32'd0); cdb(1, 32'd20, 32'd0);
    chk("t1_w1", {rf_we, 26'd0, rf_waddr} ^ rf_wdata, {1'b1, 26'd0, 5'd1} ^ 32'd10);
    cycle();
    chk("t1_w2_addr", 32'(rf_waddr), 32'd2);
    chk("t1_w2_data", rf_wdata, 32'd20);
    cycle();
    chk("t1_w3_addr", 32'(rf_waddr), 32'd3);
    chk("t1_w3_data", rf_wdata, 32'd30);
    cycle(); cycle();
    chk("t1_busy_clear", 32'(busy_rb), 32'h00);
    chk("t1_count", retire_count, 32'd3);

    // Full ROB, then retire of the head only
    restart();
    for (int i = 0; i < 8; i++) issue(i, i + 8, 1'b0);
    cycle();
    chk("t2_full", 32'(busy_rb), 32'hFF);
    cdb(0, 32'd100, 32'd0);
    cycle();
    chk("t2_rf_we", 32'(rf_we), 32'd1);
    chk("t2_head", 32'(head_idx), 32'd1);
    chk("t2_busy_lag", 32'(busy_rb), 32'hFF);
    cycle();
    chk("t2_busy_freed", 32'(busy_rb), 32'hFE);
    for (int i = 1; i < 8; i++) cdb(i, 32'(200 + i), 32'd0);
    repeat (3) cycle();
    chk("t2_wrap_head", 32'(head_idx), 32'd0);

    // Store with delayed acknowledge
    issue(0, 9, 1'b1);
    cdb(0, 32'h55, 32'h40);
    cycle();
    chk("t3_req", 32'(store_req), 32'd1);
    repeat (3) begin
      cycle();
      chk("t3_hold_addr", store_addr, 32'h40);
      chk("t3_hold_data", store_data, 32'h55);
      chk("t3_no_rf", 32'(rf_we), 32'd0);
    end
    store_ack = 1'b1;
    cycle();
    store_ack = 1'b0;
    chk("t3_req_drop", 32'(store_req), 32'd0);
    chk("t3_head", 32'(head_idx), 32'd1);
    cycle();

    // Issue and CDB on the same index: CDB dropped
    issue_valid = 1'b1; issue_rob_idx = 3'd1; issue_dest = 5'd4; issue_is_store = 1'b0;
    cdb_valid = 1'b1; cdb_rob_idx = 3'd1; cdb_value = 32'h77; cdb_addr = 32'd0;
    cycle();
    idle_inputs();
    cycle(); cycle();
    chk("t4_not_done", 32'(head_idx), 32'd1);
    cdb(1, 32'h99, 32'd0);
    cycle();
    chk("t4_rf_data", rf_wdata, 32'h99);
    chk("t4_rf_addr", 32'(rf_waddr), 32'd4);

    // start low during STORE_WAIT with five busy entries
    restart();
    issue(0, 1, 1'b1);
    for (int i = 1; i < 5; i++) issue(i, i, 1'b0);
    cdb(0, 32'hAA, 32'h10);
    cycle();
    chk("t5_req", 32'(store_req), 32'd1);
    chk("t5_busy", 32'(busy_rb), 32'h1F);
    start = 1'b0;
    cycle();
    chk("t5_flush_busy", 32'(busy_rb), 32'h0);
    chk("t5_flush_req", 32'(store_req), 32'd0);
    start = 1'b1;
    issue(0, 1, 1'b0); issue(1, 2, 1'b0);
    cdb(0, 32'd5, 32'd0);
    cycle();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("t5_arst_busy", 32'(busy_rb), 32'h0);
    chk("t5_arst_count", retire_count, 32'd0);
    check_all();
    #2;
    rst_n = 1'b1;

    // Twenty instructions wrapping through the ROB
    restart();
    for (int k = 0; k < 20; k++) begin
      issue(k % 8, k % 32, 1'b0);
      cdb(k % 8, 32'(k), 32'd0);
    end
    repeat (3) cycle();
    chk("t6_count", retire_count, 32'd20);
    chk("t6_head", 32'(head_idx), 32'd4);
    chk("t6_err", 32'(alloc_err), 32'd0);

    // Randomized traffic against the model
    nxt = 0;
    for (int c = 0; c < 800; c++) begin
      idle_inputs();
      start = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 99) < 55) begin
        issue_dest = 5'($urandom);
        issue_is_store = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 99) < 3) begin
          issue_valid = 1'b1; issue_rob_idx = 3'($urandom);
        end else if (!m_vis[nxt]) begin
          issue_valid = 1'b1; issue_rob_idx = 3'(nxt); nxt = (nxt + 1) % 8;
        end
      end
      if ($urandom_range(0, 99) < 50) begin
        cdb_valid = 1'b1; cdb_rob_idx = 3'($urandom);
        cdb_value = $urandom; cdb_addr = $urandom;
      end
      store_ack = ($urandom_range(0, 2) == 0);
      cycle();
      if (!start) nxt = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
